// File: rtl/dspba_pipe_sched_pkg.sv
// Shared types and limits for the DSPBA pipe scheduler: shadow-stage record,
// requester-id width helper and parameter ranges.
package dspba_pipe_sched_pkg;

  localparam int unsigned MAX_REQS      = 16;
  localparam int unsigned MAX_LATENCY   = 64;
  localparam int unsigned MAX_TAG_WIDTH = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned STAGE_ID_W = id_width(MAX_REQS);

  // One shadow stage; tag sized for the widest supported tag.
  typedef struct packed {
    logic                     valid;
    logic [STAGE_ID_W-1:0]    req_id;
    logic [MAX_TAG_WIDTH-1:0] tag;
  } stage_t;

endpackage

// File: rtl/dspba_pipe_sched_if.sv
// Requester / core / response signal bundle for the DSPBA pipe scheduler.
interface dspba_pipe_sched_if #(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RES_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH  = 8
);
  logic [NUM_REQS-1:0]                 req_valid;
  logic [NUM_REQS-1:0]                 req_ready;
  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]  req_tag;
  logic                                core_ena;
  logic [DATA_WIDTH-1:0]               core_din;
  logic [RES_WIDTH-1:0]                core_dout;
  logic [NUM_REQS-1:0]                 rsp_valid;
  logic [NUM_REQS-1:0]                 rsp_ready;
  logic [RES_WIDTH-1:0]                rsp_data;
  logic [TAG_WIDTH-1:0]                rsp_tag;

  modport master (
    output req_valid, req_data, req_tag, core_dout, rsp_ready,
    input  req_ready, core_ena, core_din, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_data, req_tag, core_dout, rsp_ready,
    output req_ready, core_ena, core_din, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/dspba_pipe_sched_track.sv
// Shadow pipe that follows the DSPBA core: LATENCY enabled stages of
// {valid, req_id, tag}, async clear.
module dspba_pipe_sched_track
  import dspba_pipe_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic   clk,
  input  logic   aclr_n,
  input  logic   ena,
  input  stage_t din,
  output stage_t tail
);

  stage_t [LATENCY-1:0] pipe_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      pipe_q <= '0;
    end else if (ena) begin
      pipe_q[0] <= din;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[LATENCY-1];

endmodule

// File: rtl/dspba_pipe_sched.sv
// Round-robin issue scheduler for a shared fixed-latency DSPBA core.
// Optional 2-entry output skid buffer: define DSPBA_PIPE_SCHED_SKID_EN.
module dspba_pipe_sched
  import dspba_pipe_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS   = 4,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RES_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input logic               clk,
  input logic               aclr_n,
  dspba_pipe_sched_if.slave bus
);

  localparam int unsigned IW = id_width(NUM_REQS);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] winner_c;
  logic [IW-1:0] idx_c;
  logic [IW-1:0] tail_id_c;
  logic          any_valid_c;
  logic          accept_c;
  logic          core_ena_c;
  stage_t        stage_in_c;
  stage_t        tail;
  logic          unused_c;

  // First valid requester searching upward from rr_ptr
  always_comb begin
    winner_c    = '0;
    idx_c       = '0;
    any_valid_c = 1'b0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      idx_c = IW'((32'(rr_ptr_q) + k) % NUM_REQS);
      if (!any_valid_c && bus.req_valid[idx_c]) begin
        any_valid_c = 1'b1;
        winner_c    = idx_c;
      end
    end
  end

  // Reset gates the grant so nothing is offered while aclr_n is low
  assign accept_c = aclr_n && core_ena_c && any_valid_c;

  always_comb begin
    bus.req_ready = '0;
    if (accept_c) bus.req_ready[winner_c] = 1'b1;
    bus.core_din = any_valid_c ? bus.req_data[winner_c] : '0;
    bus.core_ena = core_ena_c;
  end

  always_comb begin
    stage_in_c        = '0;
    stage_in_c.valid  = accept_c;
    stage_in_c.req_id = STAGE_ID_W'(winner_c);
    stage_in_c.tag    = MAX_TAG_WIDTH'(bus.req_tag[winner_c]);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)       rr_ptr_q <= '0;
    else if (accept_c) rr_ptr_q <= IW'((32'(winner_c) + 32'd1) % NUM_REQS);
  end

  dspba_pipe_sched_track #(.LATENCY(LATENCY)) u_track (
    .clk    (clk),
    .aclr_n (aclr_n),
    .ena    (core_ena_c),
    .din    (stage_in_c),
    .tail   (tail)
  );

  assign tail_id_c = IW'(tail.req_id);
  assign unused_c  = ^tail;

`ifdef DSPBA_PIPE_SCHED_SKID_EN
  typedef struct packed {
    logic [IW-1:0]        id;
    logic [TAG_WIDTH-1:0] tag;
    logic [RES_WIDTH-1:0] data;
  } skid_t;

  skid_t      skid_q [2];
  logic [1:0] cnt_q;
  logic [1:0] cnt_next_c;
  logic       rd_q;
  logic       wr_q;
  logic       skid_full_q;
  skid_t      tail_e_c;
  skid_t      out_c;
  logic       out_valid_c;
  logic       take_c;
  logic       push_c;
  logic       pop_c;

  // Empty buffer bypasses the tail straight to the response bus
  always_comb begin
    tail_e_c    = '{id: tail_id_c, tag: TAG_WIDTH'(tail.tag), data: bus.core_dout};
    out_c       = (cnt_q != 2'd0) ? skid_q[rd_q] : tail_e_c;
    out_valid_c = (cnt_q != 2'd0) || tail.valid;
    take_c      = out_valid_c && bus.rsp_ready[out_c.id];
    pop_c       = take_c && (cnt_q != 2'd0);
    push_c      = core_ena_c && tail.valid && !((cnt_q == 2'd0) && take_c);
    cnt_next_c  = 2'(cnt_q + 2'(push_c) - 2'(pop_c));
  end

  assign core_ena_c = !skid_full_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_next_c;
      skid_full_q <= (cnt_next_c == 2'd2);
      if (push_c) wr_q <= !wr_q;
      if (pop_c)  rd_q <= !rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) skid_q[wr_q] <= tail_e_c;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (out_valid_c) bus.rsp_valid[out_c.id] = 1'b1;
    bus.rsp_data = out_c.data;
    bus.rsp_tag  = out_c.tag;
  end
`else
  // A stalled tail freezes the core and the shadow pipe together
  assign core_ena_c = !tail.valid || bus.rsp_ready[tail_id_c];

  always_comb begin
    bus.rsp_valid = '0;
    if (tail.valid) bus.rsp_valid[tail_id_c] = 1'b1;
    bus.rsp_data = bus.core_dout;
    bus.rsp_tag  = TAG_WIDTH'(tail.tag);
  end
`endif

endmodule

// File: tb/tb_dspba_pipe_sched.sv
// Directed bench for dspba_pipe_sched with a scoreboard and a stand-in core.
module tb_dspba_pipe_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 4;
  localparam int unsigned DW  = 64;
  localparam int unsigned RSW = 32;
  localparam int unsigned TW  = 8;
  localparam int unsigned IW  = 2;

  logic clk = 1'b0;
  logic aclr_n;
  always #5 clk = ~clk;

  dspba_pipe_sched_if #(.NUM_REQS(NR), .DATA_WIDTH(DW), .RES_WIDTH(RSW), .TAG_WIDTH(TW)) bus ();

  dspba_pipe_sched #(
    .NUM_REQS(NR), .LATENCY(LAT), .DATA_WIDTH(DW), .RES_WIDTH(RSW), .TAG_WIDTH(TW)
  ) dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  function automatic logic [RSW-1:0] core_fn(input logic [DW-1:0] d);
    return d[31:0] ^ d[63:32] ^ 32'h5a5a_0f0f;
  endfunction

  // Stand-in DSPBA core: clock-enabled delay line of core_fn
  logic [RSW-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    if (bus.core_ena) begin
      core_pipe[0] <= core_fn(bus.core_din);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign bus.core_dout = core_pipe[LAT-1];

  typedef struct {
    logic [IW-1:0]  id;
    logic [TW-1:0]  tag;
    logic [RSW-1:0] res;
    int unsigned    age;
  } exp_t;

  typedef struct {
    int unsigned   cyc;
    logic [IW-1:0] id;
    logic [TW-1:0] tag;
  } pop_t;

  exp_t          sb[$];
  pop_t          pops[$];
  logic [IW-1:0] grants[$];
  logic [IW-1:0] rr_m;
  int unsigned   cyc, n_vec, n_err, n_acc, c0, start;
  logic [NR-1:0] s_rsp_valid, s_req_ready;
  logic [RSW-1:0] s_rsp_data, h_data;
  logic [TW-1:0] s_rsp_tag, h_tag, tagctr;
  logic          s_core_ena;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [TW-1:0] t);
    bus.req_data[IW'(i)] = {$urandom, $urandom};
    bus.req_tag[IW'(i)]  = t;
  endtask

  // One clock: check outputs at negedge, update the model, return after posedge
  task automatic step();
    logic          hv, any, ena, exp_ena;
    logic [NR-1:0] exp_rv, exp_rr;
    logic [IW-1:0] w, idx;
    @(negedge clk);
    cyc++;
    s_rsp_valid = bus.rsp_valid;
    s_rsp_data  = bus.rsp_data;
    s_rsp_tag   = bus.rsp_tag;
    s_core_ena  = bus.core_ena;
    s_req_ready = bus.req_ready;
    if (!aclr_n) begin
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
      sb.delete();
      rr_m = '0;
    end else begin
      hv = (sb.size() > 0) && (sb[0].age >= LAT);
      exp_rv  = '0;
      exp_ena = 1'b1;
      if (hv) begin
        exp_rv[sb[0].id] = 1'b1;
        exp_ena = bus.rsp_ready[sb[0].id];
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(sb[0].tag));
        chk("rsp_data", 64'(bus.rsp_data), 64'(sb[0].res));
      end
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
`ifndef DSPBA_PIPE_SCHED_SKID_EN
      chk("core_ena", 64'(bus.core_ena), 64'(exp_ena));
`endif
      ena = bus.core_ena;
      any = 1'b0;
      w   = '0;
      for (int unsigned k = 0; k < NR; k++) begin
        idx = IW'(rr_m + IW'(k));
        if (!any && bus.req_valid[idx]) begin
          any = 1'b1;
          w   = idx;
        end
      end
      exp_rr = '0;
      if (ena && any) exp_rr[w] = 1'b1;
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
      chk("core_din", 64'(bus.core_din), any ? 64'(bus.req_data[w]) : 64'(0));
      if (hv && bus.rsp_ready[sb[0].id]) begin
        pops.push_back('{cyc: cyc, id: sb[0].id, tag: sb[0].tag});
        void'(sb.pop_front());
      end
      if (ena) foreach (sb[i]) if (sb[i].age < LAT) sb[i].age++;
      if (ena && any) begin
        sb.push_back('{id: w, tag: bus.req_tag[w], res: core_fn(bus.req_data[w]), age: 1});
        rr_m = IW'(w + 1'b1);
        grants.push_back(w);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; n_acc = 0; cyc = 0; rr_m = '0; tagctr = '0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_tag = '0; bus.rsp_ready = '1;
    aclr_n = 1'b1;
    #1 aclr_n = 1'b0;

    // Reset with every requester asking: nothing granted, nothing returned
    for (int i = 0; i < NR; i++) set_req(i, TW'(8'h20 + i));
    bus.req_valid = '1;
    step(); step();
    bus.req_valid = '0;
    aclr_n = 1'b1;
    #1 chk("ena_after_rst", 64'(bus.core_ena), 64'(1));

    // All four requesters continuously valid: 0,1,2,3,0... one accept per cycle
    grants.delete();
    start = n_acc;
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      for (int r = 0; r < NR; r++) set_req(r, tagctr++);
    end
    bus.req_valid = '0;
    chk("rr_accepts", 64'(n_acc - start), 64'(8));
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(grants[i]), 64'(i % NR));
    drain();

    // Single req0, tag 0x11: response exactly LAT cycles after issue
    pops.delete();
    set_req(0, 8'h11);
    bus.req_valid = 4'b0001;
    step();
    c0 = cyc;
    bus.req_valid = '0;
    drain();
    chk("single_count", 64'(pops.size()), 64'(1));
    if (pops.size() > 0) begin
      chk("single_latency", 64'(pops[0].cyc - c0), 64'(LAT));
      chk("single_tag", 64'(pops[0].tag), 64'(8'h11));
    end

    // Stall tail id 2 while req0/req1 keep asking
    set_req(2, 8'h33);
    bus.req_valid = 4'b0100;
    step();
    bus.rsp_ready[2] = 1'b0;
    set_req(0, 8'h40); set_req(1, 8'h41);
    bus.req_valid = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rsp_valid[2]) break;
    end
    chk("stall_reached", 64'(s_rsp_valid[2]), 64'(1));
    h_data = s_rsp_data;
    h_tag  = s_rsp_tag;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 64'(s_rsp_valid), 64'(4'b0100));
      chk("stall_data", 64'(s_rsp_data), 64'(h_data));
      chk("stall_tag", 64'(s_rsp_tag), 64'(h_tag));
`ifndef DSPBA_PIPE_SCHED_SKID_EN
      chk("stall_ena", 64'(s_core_ena), 64'(0));
      chk("stall_ready", 64'(s_req_ready), 64'(0));
`endif
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    drain();

    // Bubble between two ops: responses one idle cycle apart, in order
    pops.delete();
    set_req(1, 8'hA1);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step();
    set_req(3, 8'hB3);
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    drain();
    chk("bubble_count", 64'(pops.size()), 64'(2));
    if (pops.size() == 2) begin
      chk("bubble_gap", 64'(pops[1].cyc - pops[0].cyc), 64'(2));
      chk("bubble_tag0", 64'(pops[0].tag), 64'(8'hA1));
      chk("bubble_tag1", 64'(pops[1].tag), 64'(8'hB3));
    end

    // Reset with three ops in flight: dropped, pointer back to req0
    for (int i = 0; i < NR; i++) set_req(i, TW'(8'h60 + i));
    bus.req_valid = 4'b0111;
    repeat (3) step();
    bus.req_valid = '0;
    aclr_n = 1'b0;
    step(); step();
    aclr_n = 1'b1;
    pops.delete();
    grants.delete();
    bus.req_valid = '1;
    step();
    bus.req_valid = '0;
    chk("rst_grant_count", 64'(grants.size()), 64'(1));
    if (grants.size() > 0) chk("rst_grant_id", 64'(grants[0]), 64'(0));
    drain();
    chk("rst_pops", 64'(pops.size()), 64'(1));

    // 100 ops with rsp_ready toggling every cycle
    pops.delete();
    start = n_acc;
    for (int i = 0; i < 3000; i++) begin
      if (n_acc >= start + 100) break;
      bus.rsp_ready = (i % 2 == 1) ? 4'b1111 : 4'b0000;
      for (int r = 0; r < NR; r++) set_req(r, tagctr++);
      bus.req_valid = NR'($urandom);
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    drain();
    chk("toggle_accepts", 64'(n_acc - start), 64'(100));
    chk("toggle_pops", 64'(pops.size()), 64'(100));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dspba_pipe_sched.md
DSPBA_PIPE_SCHED -- requirements
Module: dspba_pipe_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requesters sharing one fixed-latency DSPBA core (range 1..16).
REQ-002 SHALL have parameter LATENCY, default 4: core pipeline depth in enabled cycles (range 1..64).
REQ-003 SHALL have parameter DATA_WIDTH, default 64: operand bus width.
REQ-004 SHALL have parameter RES_WIDTH, default 32: result width.
REQ-005 SHALL have parameter TAG_WIDTH, default 8: requester tag width.
REQ-006 SHALL have port clk, input, 1: single clock; all logic rises on posedge.
REQ-007 SHALL have port aclr_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have ports req_valid / req_ready, input / output, NUM_REQS each: per-requester issue handshake.
REQ-009 SHALL have ports req_data / req_tag, input, NUM_REQS x DATA_WIDTH / NUM_REQS x TAG_WIDTH: operands and tag.
REQ-010 SHALL have ports core_ena / core_din, output, 1 / DATA_WIDTH: core clock enable and muxed operands.
REQ-011 SHALL have port core_dout, input, RES_WIDTH: core result, valid LATENCY enabled cycles after core_din.
REQ-012 SHALL have ports rsp_valid / rsp_ready, output / input, NUM_REQS each: per-requester response handshake.
REQ-013 SHALL have ports rsp_data / rsp_tag, output, RES_WIDTH / TAG_WIDTH: shared response bus, qualified by rsp_valid.

Function
REQ-014 SHALL grant round-robin: winner = first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQS.
REQ-015 SHALL assert req_ready[i] only for the winner and only when core_ena=1; all other req_ready bits 0.
REQ-016 SHALL advance rr_ptr to winner+1 (mod NUM_REQS) on accept, else hold.
REQ-017 SHALL drive core_din = req_data[winner], and 0 when no req_valid bit is set.
REQ-018 SHALL track {valid, req_id, tag} through a LATENCY-stage shadow pipe, advancing only when core_ena=1, so it stays aligned with the core.
REQ-019 SHALL load stage 0 with valid=0 (bubble) on an enabled cycle with no accept.
REQ-020 SHALL assert rsp_valid[id] only for the tail stage's id when the tail is valid, with rsp_data=core_dout and rsp_tag=tail tag.
REQ-021 SHALL drive core_ena = !tail_valid || rsp_ready[tail_id]; a stall freezes the whole pipe, including bubbles.
REQ-022 SHALL have an issue-to-rsp_valid latency of exactly LATENCY cycles when there is no stall.
REQ-023 SHALL sustain one accept per cycle under continuous rsp_ready; accept and retire in one cycle are legal.
REQ-024 SHALL keep rsp_valid, rsp_data and rsp_tag stable while stalled until the response is taken.

Reset
REQ-025 SHALL on aclr_n low, immediately clear all shadow valid bits, clear rr_ptr to 0, and drive rsp_valid=0 and req_ready=0.
REQ-026 SHALL drop any in-flight operation on reset mid-operation with no response; core_ena=1 after reset release.

Configuration
REQ-027 SHALL, with DSPBA_PIPE_SCHED_SKID_EN defined, add a 2-entry output skid buffer and drive core_ena = !skid_full from a register, with no combinational path from rsp_ready.
REQ-028 SHALL with SKID_EN keep latency at LATENCY when the buffer is empty and preserve response order; without the macro, follow REQ-021.

Structure
REQ-029 SHALL place the shadow-stage struct typedef {valid, req_id, tag}, the req_id width function and the parameter limits in package dspba_pipe_sched_pkg.
REQ-030 SHALL implement the shadow pipe as sub-module dspba_pipe_sched_track: LATENCY stages with enable and async clear.

Verification
REQ-031 SHALL cover: single req0 with tag 0x11, LATENCY=4 -> rsp_valid[0] exactly 4 cycles later, rsp_tag=0x11.
REQ-032 SHALL cover: all 4 requesters valid continuously -> grants in order 0,1,2,3,0 and one accept per cycle.
REQ-033 SHALL cover: rsp_ready[2]=0 for 3 cycles while tail id=2 -> core_ena=0, outputs stable, no req_ready asserted.
REQ-034 SHALL cover: a bubble between two ops -> responses separated by one idle cycle; order and tags preserved.
REQ-035 SHALL cover: aclr_n pulsed with 3 ops in flight -> no rsp_valid afterwards, rr_ptr=0, next grant to req0.
REQ-036 SHALL cover: with SKID_EN, toggling rsp_ready every cycle -> no lost or duplicated responses, 100 ops in order.
